// File: rtl/instruction_fetch_controller.sv
// instruction_fetch_controller
// Owns the program counter and drives the combinational instruction memory with it.
// Each returned word is captured with its PC into a two-entry buffer that feeds decode
// through a valid/ready handshake. Taken branches and jumps redirect the PC and flush the
// buffer. Fetching stops with a fault flag when the PC leaves the populated memory.

module instruction_fetch_controller #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 1024
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic [31:0] ImemAddress,
  input  logic [31:0] ImemInstruction,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [31:0] OutInstruction,
  output logic [31:0] OutPC,
  output logic [31:0] OutPCPlus4,
  input  logic        RedirectValid,
  input  logic [31:0] RedirectTarget,
  output logic        Halt,
  output logic [31:0] FaultPC
);

  // The low two address bits are always cleared, so a misaligned constant cannot leak in
  localparam logic [31:0] C_RESET_PC   = RESET_PC & 32'hFFFF_FFFC;
  localparam logic [31:0] C_IMEM_LIMIT = 32'(IMEM_WORDS);

  typedef enum logic {
    FETCH = 1'b0,
    FAULT = 1'b1
  } state_t;

  state_t      r_state;
  logic        r_halt;
  logic [31:0] r_faultPc;
  logic [31:0] r_pc;

  // Entry 0 is always the head; entry 1 is the second-oldest word
  logic [31:0] r_fifoPc    [2];
  logic [31:0] r_fifoInstr [2];
  logic [1:0]  r_count;

  logic [31:0] w_wordIndex;
  logic        w_inRange;
  logic        w_isFetch;
  logic        w_pop;
  logic        w_push;
  logic        w_faultDetect;
  logic [31:0] w_redirectPc;

  logic [1:0]  w_countAfterPop;
  logic [1:0]  w_nextCount;
  logic [31:0] w_nextPc0;
  logic [31:0] w_nextPc1;
  logic [31:0] w_nextInstr0;
  logic [31:0] w_nextInstr1;

  assign w_wordIndex  = {2'b00, r_pc[31:2]};
  assign w_inRange    = (w_wordIndex < C_IMEM_LIMIT);
  assign w_isFetch    = (r_state == FETCH);
  assign w_pop        = (r_count != 2'd0) && OutReady;
  assign w_redirectPc = RedirectTarget & 32'hFFFF_FFFC;

  // A push needs a free slot, or a slot that the pop in this same cycle is freeing
  assign w_push        = w_isFetch && !RedirectValid && w_inRange &&
                         ((r_count != 2'd2) || w_pop);
  assign w_faultDetect = w_isFetch && !RedirectValid && !w_inRange;

  // Buffer next-state: shift the second entry to the head on a pop, then append at the tail
  always_comb begin
    w_nextPc0       = r_fifoPc[0];
    w_nextPc1       = r_fifoPc[1];
    w_nextInstr0    = r_fifoInstr[0];
    w_nextInstr1    = r_fifoInstr[1];
    w_countAfterPop = r_count;

    if (w_pop) begin
      w_nextPc0       = r_fifoPc[1];
      w_nextInstr0    = r_fifoInstr[1];
      w_countAfterPop = r_count - 2'd1;
    end

    if (w_push) begin
      if (w_countAfterPop == 2'd0) begin
        w_nextPc0    = r_pc;
        w_nextInstr0 = ImemInstruction;
      end else begin
        w_nextPc1    = r_pc;
        w_nextInstr1 = ImemInstruction;
      end
    end

    w_nextCount = w_countAfterPop + {1'b0, w_push};
  end

  // Buffer payload registers; contents beyond the count are don't-care so they need no reset
  always_ff @(posedge Clk) begin
    r_fifoPc[0]    <= w_nextPc0;
    r_fifoPc[1]    <= w_nextPc1;
    r_fifoInstr[0] <= w_nextInstr0;
    r_fifoInstr[1] <= w_nextInstr1;
  end

  // Occupancy: a redirect flushes everything, including anything the pop did not consume
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_count <= 2'd0;
    end else if (RedirectValid) begin
      r_count <= 2'd0;
    end else begin
      r_count <= w_nextCount;
    end
  end

  // Program counter: jumps on redirect, advances only when the current word was captured
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_pc <= C_RESET_PC;
    end else if (RedirectValid) begin
      r_pc <= w_redirectPc;
    end else if (w_push) begin
      r_pc <= r_pc + 32'd4;
    end
  end

  // Fetch/fault state machine with registered Halt and fault address
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= FETCH;
      r_halt    <= 1'b0;
      r_faultPc <= 32'd0;
    end else if (RedirectValid) begin
      r_state <= FETCH;
      r_halt  <= 1'b0;
    end else begin
      case (r_state)
        FETCH: begin
          if (w_faultDetect) begin
            r_state   <= FAULT;
            r_halt    <= 1'b1;
            r_faultPc <= r_pc;
          end
        end
        FAULT: begin
          r_state <= FAULT;
          r_halt  <= 1'b1;
        end
        default: begin
          r_state <= FETCH;
          r_halt  <= 1'b0;
        end
      endcase
    end
  end

  assign ImemAddress    = r_pc;
  assign OutValid       = (r_count != 2'd0);
  assign OutInstruction = r_fifoInstr[0];
  assign OutPC          = r_fifoPc[0];
  assign OutPCPlus4     = r_fifoPc[0] + 32'd4;
  assign Halt           = r_halt;
  assign FaultPC        = r_faultPc;

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Directed bench for instruction_fetch_controller. Two instances share the clock:
// one with the default 1024-word memory and one with a 4-word memory for fault cases.
// Memory model: word i holds 32'h1000_0000 + i.

module tb_instruction_fetch_controller;

  logic        Clk;
  integer      checks;
  integer      errors;

  // Instance A: default memory size
  logic        resetA;
  logic [31:0] imemAddrA;
  logic [31:0] imemInstrA;
  logic        validA;
  logic        readyA;
  logic [31:0] instrA;
  logic [31:0] pcA;
  logic [31:0] pcPlus4A;
  logic        redirValidA;
  logic [31:0] redirTargetA;
  logic        haltA;
  logic [31:0] faultPcA;

  // Instance B: four-word memory
  logic        resetB;
  logic [31:0] imemAddrB;
  logic [31:0] imemInstrB;
  logic        validB;
  logic        readyB;
  logic [31:0] instrB;
  logic [31:0] pcB;
  logic [31:0] pcPlus4B;
  logic        redirValidB;
  logic [31:0] redirTargetB;
  logic        haltB;
  logic [31:0] faultPcB;

  assign imemInstrA = 32'h1000_0000 + {2'b00, imemAddrA[31:2]};
  assign imemInstrB = 32'h1000_0000 + {2'b00, imemAddrB[31:2]};

  instruction_fetch_controller dut (
    .Clk             (Clk),
    .Reset           (resetA),
    .ImemAddress     (imemAddrA),
    .ImemInstruction (imemInstrA),
    .OutValid        (validA),
    .OutReady        (readyA),
    .OutInstruction  (instrA),
    .OutPC           (pcA),
    .OutPCPlus4      (pcPlus4A),
    .RedirectValid   (redirValidA),
    .RedirectTarget  (redirTargetA),
    .Halt            (haltA),
    .FaultPC         (faultPcA)
  );

  instruction_fetch_controller #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_WORDS (4)
  ) dutSmall (
    .Clk             (Clk),
    .Reset           (resetB),
    .ImemAddress     (imemAddrB),
    .ImemInstruction (imemInstrB),
    .OutValid        (validB),
    .OutReady        (readyB),
    .OutInstruction  (instrB),
    .OutPC           (pcB),
    .OutPCPlus4      (pcPlus4B),
    .RedirectValid   (redirValidB),
    .RedirectTarget  (redirTargetB),
    .Halt            (haltB),
    .FaultPC         (faultPcB)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Advance one clock and settle just after the rising edge
  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic applyResetA;
    resetA       = 1'b1;
    readyA       = 1'b0;
    redirValidA  = 1'b0;
    redirTargetA = 32'd0;
    tick();
    tick();
    resetA = 1'b0;
  endtask

  task automatic applyResetB;
    resetB       = 1'b1;
    readyB       = 1'b0;
    redirValidB  = 1'b0;
    redirTargetB = 32'd0;
    tick();
    tick();
    resetB = 1'b0;
  endtask

  task automatic test_reset;
    applyResetA();
    checks++;
    if (validA !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got=%b exp=0", validA); end
    checks++;
    if (haltA !== 1'b0) begin errors++; $display("[TB] FAIL reset_halt got=%b exp=0", haltA); end
    checks++;
    if (faultPcA !== 32'd0) begin errors++; $display("[TB] FAIL reset_faultpc got=%h exp=0", faultPcA); end
    checks++;
    if (imemAddrA !== 32'd0) begin errors++; $display("[TB] FAIL reset_addr got=%h exp=0", imemAddrA); end
  endtask

  task automatic test_streaming;
    applyResetA();
    readyA = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (validA !== 1'b1) begin errors++; $display("[TB] FAIL stream_valid k=%0d got=%b exp=1", k, validA); end
      checks++;
      if (pcA !== 32'(4 * k)) begin errors++; $display("[TB] FAIL stream_pc k=%0d got=%h exp=%h", k, pcA, 32'(4 * k)); end
      checks++;
      if (instrA !== 32'h1000_0000 + 32'(k)) begin errors++; $display("[TB] FAIL stream_instr k=%0d got=%h exp=%h", k, instrA, 32'h1000_0000 + 32'(k)); end
      checks++;
      if (pcPlus4A !== 32'(4 * k + 4)) begin errors++; $display("[TB] FAIL stream_pcplus4 k=%0d got=%h exp=%h", k, pcPlus4A, 32'(4 * k + 4)); end
    end
  endtask

  task automatic test_backpressure;
    applyResetA();
    readyA = 1'b0;
    tick();
    checks++;
    if (validA !== 1'b1 || pcA !== 32'd0) begin errors++; $display("[TB] FAIL bp_first got valid=%b pc=%h exp valid=1 pc=0", validA, pcA); end
    checks++;
    if (imemAddrA !== 32'd4) begin errors++; $display("[TB] FAIL bp_addr1 got=%h exp=4", imemAddrA); end
    for (int c = 1; c < 5; c++) begin
      tick();
      checks++;
      if (imemAddrA !== 32'd8) begin errors++; $display("[TB] FAIL bp_addr_hold c=%0d got=%h exp=8", c, imemAddrA); end
      checks++;
      if (validA !== 1'b1 || pcA !== 32'd0 || instrA !== 32'h1000_0000) begin
        errors++;
        $display("[TB] FAIL bp_head_hold c=%0d got valid=%b pc=%h instr=%h exp 1/0/10000000", c, validA, pcA, instrA);
      end
    end
    readyA = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (validA !== 1'b1 || pcA !== 32'(4 * k)) begin
        errors++;
        $display("[TB] FAIL bp_drain k=%0d got valid=%b pc=%h exp valid=1 pc=%h", k, validA, pcA, 32'(4 * k));
      end
      tick();
    end
  endtask

  task automatic test_redirect_full;
    applyResetA();
    readyA = 1'b0;
    tick();
    tick();
    redirValidA  = 1'b1;
    redirTargetA = 32'h0000_0043;
    readyA       = 1'b1;
    tick();
    redirValidA = 1'b0;
    checks++;
    if (validA !== 1'b0) begin errors++; $display("[TB] FAIL redir_flush got=%b exp=0", validA); end
    checks++;
    if (imemAddrA !== 32'h40) begin errors++; $display("[TB] FAIL redir_addr got=%h exp=40", imemAddrA); end
    tick();
    checks++;
    if (validA !== 1'b1 || pcA !== 32'h40 || instrA !== 32'h1000_0010) begin
      errors++;
      $display("[TB] FAIL redir_target got valid=%b pc=%h instr=%h exp 1/40/10000010", validA, pcA, instrA);
    end
    tick();
    checks++;
    if (pcA !== 32'h44) begin errors++; $display("[TB] FAIL redir_next got=%h exp=44", pcA); end
  endtask

  task automatic test_fault;
    applyResetB();
    readyB = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (validB !== 1'b1 || pcB !== 32'(4 * k) || haltB !== 1'b0) begin
        errors++;
        $display("[TB] FAIL fault_stream k=%0d got valid=%b pc=%h halt=%b exp 1/%h/0", k, validB, pcB, haltB, 32'(4 * k));
      end
    end
    tick();
    checks++;
    if (haltB !== 1'b1) begin errors++; $display("[TB] FAIL fault_halt got=%b exp=1", haltB); end
    checks++;
    if (faultPcB !== 32'd16) begin errors++; $display("[TB] FAIL fault_pc got=%h exp=10", faultPcB); end
    checks++;
    if (validB !== 1'b0) begin errors++; $display("[TB] FAIL fault_drained got=%b exp=0", validB); end
    tick();
    checks++;
    if (haltB !== 1'b1 || validB !== 1'b0 || imemAddrB !== 32'd16) begin
      errors++;
      $display("[TB] FAIL fault_stay got halt=%b valid=%b addr=%h exp 1/0/10", haltB, validB, imemAddrB);
    end
    redirValidB  = 1'b1;
    redirTargetB = 32'd0;
    tick();
    redirValidB = 1'b0;
    checks++;
    if (haltB !== 1'b0 || imemAddrB !== 32'd0 || validB !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fault_clear got halt=%b addr=%h valid=%b exp 0/0/0", haltB, imemAddrB, validB);
    end
    tick();
    checks++;
    if (validB !== 1'b1 || pcB !== 32'd0) begin errors++; $display("[TB] FAIL fault_resume got valid=%b pc=%h exp 1/0", validB, pcB); end
    redirValidB  = 1'b1;
    redirTargetB = 32'h40;
    tick();
    redirValidB = 1'b0;
    checks++;
    if (haltB !== 1'b0 || imemAddrB !== 32'h40) begin
      errors++;
      $display("[TB] FAIL fault_oor_redirect got halt=%b addr=%h exp 0/40", haltB, imemAddrB);
    end
    tick();
    checks++;
    if (haltB !== 1'b1 || faultPcB !== 32'h40) begin
      errors++;
      $display("[TB] FAIL fault_oor_detect got halt=%b faultpc=%h exp 1/40", haltB, faultPcB);
    end
    resetB = 1'b1;
    tick();
    resetB = 1'b0;
    checks++;
    if (haltB !== 1'b0 || faultPcB !== 32'd0 || validB !== 1'b0 || imemAddrB !== 32'd0) begin
      errors++;
      $display("[TB] FAIL fault_reset got halt=%b faultpc=%h valid=%b addr=%h exp 0/0/0/0", haltB, faultPcB, validB, imemAddrB);
    end
  endtask

  task automatic test_reset_mid;
    applyResetA();
    readyA = 1'b0;
    tick();
    tick();
    resetA       = 1'b1;
    redirValidA  = 1'b1;
    redirTargetA = 32'h100;
    readyA       = 1'b1;
    tick();
    resetA      = 1'b0;
    redirValidA = 1'b0;
    checks++;
    if (validA !== 1'b0 || haltA !== 1'b0 || imemAddrA !== 32'd0 || faultPcA !== 32'd0) begin
      errors++;
      $display("[TB] FAIL resetmid got valid=%b halt=%b addr=%h faultpc=%h exp 0/0/0/0", validA, haltA, imemAddrA, faultPcA);
    end
    tick();
    checks++;
    if (validA !== 1'b1 || pcA !== 32'd0) begin errors++; $display("[TB] FAIL resetmid_resume got valid=%b pc=%h exp 1/0", validA, pcA); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] expectedPc;
    integer      pops;
    applyResetA();
    expectedPc = 32'd0;
    pops       = 0;
    for (int i = 0; i < 10; i++) begin
      readyA = (i % 2 == 0);
      if (validA && readyA) begin
        checks++;
        if (pcA !== expectedPc) begin errors++; $display("[TB] FAIL b2b_seq i=%0d got=%h exp=%h", i, pcA, expectedPc); end
        expectedPc = expectedPc + 32'd4;
        pops++;
      end
      tick();
    end
    checks++;
    if (pops !== 4) begin errors++; $display("[TB] FAIL b2b_count got=%0d exp=4", pops); end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    resetA       = 1'b1;
    readyA       = 1'b0;
    redirValidA  = 1'b0;
    redirTargetA = 32'd0;
    resetB       = 1'b1;
    readyB       = 1'b0;
    redirValidB  = 1'b0;
    redirTargetB = 32'd0;

    test_reset();
    test_streaming();
    test_backpressure();
    test_redirect_full();
    test_fault();
    test_reset_mid();
    test_back_to_back();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
